// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver: FSM encoding, frame geometry and default timing.
package ps2_pkg;
   localparam int FRAME_BITS         = 11;
   localparam int DEF_FILTER_LEN     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 200000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DPS  = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   // Edges remaining after the start bit: 8 data + parity + stop, counted down to 0.
   localparam logic [3:0] BIT_CNT_LOAD = 4'(FRAME_BITS - 2);

   // frame = {stop, parity, data[7:0]}; good when data+parity has odd weight and stop is 1.
   function automatic logic frame_ok(input logic [9:0] frame);
      return (^frame[8:0]) & frame[9];
   endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 lines, deglitches the clock and flags its falling edges.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_ps2c,
   input  logic i_ps2d,
   output logic o_ps2d,
   output logic o_fall_edge
);
   logic                  r_c_meta, r_c_sync;
   logic                  r_d_meta, r_d_sync;
   logic [FILTER_LEN-1:0] r_hist;
   logic                  r_filt;
   logic                  w_all1, w_all0;

   // r_hist holds the last FILTER_LEN synced clock samples.
   assign w_all1      = &r_hist;
   assign w_all0      = ~|r_hist;
   assign o_fall_edge = r_filt & w_all0;
   assign o_ps2d      = r_d_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_c_meta <= 1'b1;
         r_c_sync <= 1'b1;
         r_d_meta <= 1'b1;
         r_d_sync <= 1'b1;
         r_hist   <= '1;
         r_filt   <= 1'b1;
      end else begin
         r_c_meta <= i_ps2c;
         r_c_sync <= r_c_meta;
         r_d_meta <= i_ps2d;
         r_d_sync <= r_d_meta;
         r_hist   <= {r_hist[FILTER_LEN-2:0], r_c_sync};
         if (w_all1)
            r_filt <= 1'b1;
         else if (w_all0)
            r_filt <= 1'b0;
      end
   end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver with watchdog. Define PS2_PARITY_CHECK_EN to reject bad parity/stop frames.
//
// state | meaning
// IDLE  | waiting for a start bit (ps2d=0) on a filtered clock fall, gated by rx_en
// DPS   | shifting data, parity and stop bits; watchdog armed
// LOAD  | one-cycle frame completion; scan_done_tick or frame_err visible here
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = DEF_FILTER_LEN,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       rx_en,
   output logic [7:0] scan_code,
   output logic       scan_done_tick,
   output logic       frame_err
);
   localparam int                WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]      r_state;
   logic [3:0]      r_bit_cnt;
   logic [9:0]      r_frame;
   logic [WD_W-1:0] r_wd;
   logic [7:0]      r_scan;
   logic            r_tick, r_err;
   logic            w_ps2d, w_fall, w_accept, w_unused;
   logic [9:0]      w_frame_nxt;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk         (clk),
      .reset       (reset),
      .i_ps2c      (ps2c),
      .i_ps2d      (ps2d),
      .o_ps2d      (w_ps2d),
      .o_fall_edge (w_fall)
   );

   assign w_frame_nxt = {w_ps2d, r_frame[9:1]};
`ifdef PS2_PARITY_CHECK_EN
   assign w_accept = frame_ok(w_frame_nxt);
`else
   assign w_accept = 1'b1;
`endif
   assign w_unused = ^{r_frame[0], w_frame_nxt[9:8]};

   assign scan_code      = r_scan;
   assign scan_done_tick = r_tick;
   assign frame_err      = r_err;

   // Outputs are registered on the stop-bit edge so they appear during LOAD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_frame   <= '0;
         r_wd      <= '0;
         r_scan    <= 8'h00;
         r_tick    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_wd <= '0;
               if (w_fall && rx_en && !w_ps2d) begin
                  r_state   <= ST_DPS;
                  r_bit_cnt <= BIT_CNT_LOAD;
                  r_frame   <= '0;
               end
            end
            ST_DPS: begin
               if (w_fall) begin
                  r_wd    <= '0;
                  r_frame <= w_frame_nxt;
                  if (r_bit_cnt == 4'd0) begin
                     r_state <= ST_LOAD;
                     if (w_accept) begin
                        r_tick <= 1'b1;
                        r_scan <= w_frame_nxt[7:0];
                     end else begin
                        r_err <= 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 4'd1;
                  end
               end else if (r_wd == WD_LAST) begin
                  r_state <= ST_IDLE;
                  r_wd    <= '0;
                  r_err   <= 1'b1;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end
            ST_LOAD: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of whole frames plus glitch, timeout and reset sequences.
module tb_ps2_rx;
   localparam int TO   = 400;
   localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic       rx_en = 1'b0;
   logic [7:0] scan_code;
   logic       scan_done_tick;
   logic       frame_err;

   ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .reset          (reset),
      .ps2c           (ps2c),
      .ps2d           (ps2d),
      .rx_en          (rx_en),
      .scan_code      (scan_code),
      .scan_done_tick (scan_done_tick),
      .frame_err      (frame_err)
   );

   always #5 clk = ~clk;

   int tick_cnt = 0;
   int err_cnt  = 0;
   int bad_cnt  = 0;
   bit prev_tick = 1'b0;
   bit prev_err  = 1'b0;

   always @(negedge clk) begin
      if (scan_done_tick) tick_cnt++;
      if (frame_err) err_cnt++;
      if (scan_done_tick && frame_err) bad_cnt++;
      if ((scan_done_tick && prev_tick) || (frame_err && prev_err)) bad_cnt++;
      prev_tick = scan_done_tick;
      prev_err  = frame_err;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // en_mode: 0 rx_en low throughout, 1 high throughout, 2 high only for the start bit.
   task automatic send_bits(input logic [10:0] bits, input int nbits, input int en_mode);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2d  = bits[i];
         rx_en = (en_mode == 1) || (en_mode == 2 && i == 0);
         repeat (HALF) @(negedge clk);
         ps2c = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2c = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2d  = 1'b1;
      rx_en = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         en_mode;
      int         exp_ticks;
      int         exp_errs;
      logic [7:0] exp_code;
   } vec_t;

   vec_t vecs[12];
   int   t0, e0;

   initial begin
      vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 1, 0, 8'h1C};
      vecs[1]  = '{8'hF0, 1'b1, 1'b1, 1, 1, 0, 8'hF0};
      vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1, 1, 0, 8'h1C};
      vecs[3]  = '{8'hF0, 1'b1, 1'b1, 1, 1, 0, 8'hF0};
      vecs[4]  = '{8'h1C, 1'b1, 1'b1, 1, PAR_CHK ? 0 : 1, PAR_CHK ? 1 : 0,
                   PAR_CHK ? 8'hF0 : 8'h1C};
      vecs[5]  = '{8'h29, 1'b0, 1'b1, 1, 1, 0, 8'h29};
      vecs[6]  = '{8'h55, 1'b1, 1'b0, 1, PAR_CHK ? 0 : 1, PAR_CHK ? 1 : 0,
                   PAR_CHK ? 8'h29 : 8'h55};
      vecs[7]  = '{8'h77, 1'b1, 1'b1, 0, 0, 0, PAR_CHK ? 8'h29 : 8'h55};
      vecs[8]  = '{8'h62, 1'b0, 1'b1, 2, 1, 0, 8'h62};
      vecs[9]  = '{8'hA5, 1'b1, 1'b1, 1, 1, 0, 8'hA5};
      vecs[10] = '{8'h00, 1'b1, 1'b1, 1, 1, 0, 8'h00};
      vecs[11] = '{8'hFF, 1'b1, 1'b1, 1, 1, 0, 8'hFF};

      repeat (3) @(negedge clk);
      check("rst_code", int'(scan_code), 0);
      check("rst_tick", int'(scan_done_tick), 0);
      check("rst_err", int'(frame_err), 0);
      reset = 1'b1;
      rx_en = 1'b1;
      repeat (30) @(negedge clk);

      for (int v = 0; v < 12; v++) begin
         t0 = tick_cnt;
         e0 = err_cnt;
         send_bits(mk(vecs[v].data, vecs[v].par, vecs[v].stop), 11, vecs[v].en_mode);
         check($sformatf("v%0d_ticks", v), tick_cnt - t0, vecs[v].exp_ticks);
         check($sformatf("v%0d_errs", v), err_cnt - e0, vecs[v].exp_errs);
         check($sformatf("v%0d_code", v), int'(scan_code), int'(vecs[v].exp_code));
      end

      // Short low glitch on ps2c with data low must not be taken as a start bit.
      @(negedge clk);
      ps2d = 1'b0;
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      ps2d = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_ticks", tick_cnt, t0 + vecs[11].exp_ticks);
      t0 = tick_cnt;
      e0 = err_cnt;
      send_bits(mk(8'h3A, 1'b1, 1'b1), 11, 1);
      check("glitch_next_ticks", tick_cnt - t0, 1);
      check("glitch_next_errs", err_cnt - e0, 0);
      check("glitch_next_code", int'(scan_code), 'h3A);

      // Frame abandoned after 5 bits: watchdog drops it.
      t0 = tick_cnt;
      e0 = err_cnt;
      send_bits(mk(8'hC3, 1'b1, 1'b1), 5, 1);
      repeat (TO + 200) @(negedge clk);
      check("timeout_errs", err_cnt - e0, 1);
      check("timeout_ticks", tick_cnt - t0, 0);
      check("timeout_code", int'(scan_code), 'h3A);
      t0 = tick_cnt;
      send_bits(mk(8'h29, 1'b0, 1'b1), 11, 1);
      check("after_to_ticks", tick_cnt - t0, 1);
      check("after_to_code", int'(scan_code), 'h29);

      // Reset in the middle of a frame.
      t0 = tick_cnt;
      e0 = err_cnt;
      send_bits(mk(8'h1C, 1'b0, 1'b1), 5, 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_code", int'(scan_code), 0);
      check("midrst_tick", int'(scan_done_tick), 0);
      check("midrst_err", int'(frame_err), 0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("midrst_ticks", tick_cnt - t0, 0);
      send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 1);
      check("postrst_ticks", tick_cnt - t0, 1);
      check("postrst_errs", err_cnt - e0, 0);
      check("postrst_code", int'(scan_code), 'h1C);

      check("pulse_shape", bad_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
